// File: rtl/weight_load_ctrl_1x8.sv
// rtl/weight_load_ctrl_1x8.sv - streams 72-bit weight beats bank-major into eight weight banks
module weight_load_ctrl_1x8 #(
    parameter int DEPTH    = 512,
    parameter int ADDR_BIT = 9
) (
    input  logic                clk,
    input  logic                rst_n,
    input  logic                start,
    input  logic [ADDR_BIT:0]   words_per_bank,
    input  logic                wt_valid,
    input  logic [71:0]         wt_data,
    output logic                wt_ready,
    output logic [ADDR_BIT-1:0] write_addr_0,
    output logic [ADDR_BIT-1:0] write_addr_1,
    output logic [ADDR_BIT-1:0] write_addr_2,
    output logic [ADDR_BIT-1:0] write_addr_3,
    output logic [ADDR_BIT-1:0] write_addr_4,
    output logic [ADDR_BIT-1:0] write_addr_5,
    output logic [ADDR_BIT-1:0] write_addr_6,
    output logic [ADDR_BIT-1:0] write_addr_7,
    output logic                write_en_0,
    output logic                write_en_1,
    output logic                write_en_2,
    output logic                write_en_3,
    output logic                write_en_4,
    output logic                write_en_5,
    output logic                write_en_6,
    output logic                write_en_7,
    output logic [71:0]         weight_in,
    output logic                busy,
    output logic                done
);

    typedef enum logic [1:0] {IDLE, LOAD, DONE} state_t;

    localparam logic [ADDR_BIT:0] DEPTH_W = (ADDR_BIT + 1)'(DEPTH);
    localparam logic [ADDR_BIT:0] ONE_W   = (ADDR_BIT + 1)'(1);

    state_t              state;
    state_t              state_nxt;
    logic [ADDR_BIT:0]   n_lat;
    logic [ADDR_BIT:0]   n_start;
    logic [2:0]          bank;
    logic [ADDR_BIT-1:0] addr;
    logic [ADDR_BIT-1:0] waddr;
    logic [7:0]          wen;
    logic                start_ok;
    logic                accept;
    logic                last_word;
    logic                last_beat;

    assign n_start   = (words_per_bank > DEPTH_W) ? DEPTH_W : words_per_bank;
    assign start_ok  = (state == IDLE) && start;
    assign accept    = wt_valid && wt_ready;
    assign last_word = ({1'b0, addr} == (n_lat - ONE_W));
    assign last_beat = last_word && (bank == 3'd7);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state <= IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    always_comb begin
        state_nxt = state;
        case (state)
            IDLE: begin
                if (start) begin
                    state_nxt = (n_start == '0) ? DONE : LOAD;
                end
            end
            LOAD: begin
                if (accept && last_beat) begin
                    state_nxt = DONE;
                end
            end
            DONE:    state_nxt = IDLE;
            default: state_nxt = IDLE;
        endcase
    end

    // The write stage is one cycle behind acceptance, so the final write lands in the DONE cycle.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            n_lat     <= '0;
            bank      <= '0;
            addr      <= '0;
            waddr     <= '0;
            wen       <= '0;
            weight_in <= '0;
            wt_ready  <= 1'b0;
        end else begin
            wen <= '0;
            if (start_ok) begin
                n_lat    <= n_start;
                bank     <= '0;
                addr     <= '0;
                wt_ready <= (n_start != '0);
            end
            if (accept) begin
                weight_in <= wt_data;
                waddr     <= addr;
                wen       <= 8'b1 << bank;
                if (last_word) begin
                    addr <= '0;
                    bank <= bank + 3'd1;
                end else begin
                    addr <= addr + 1'b1;
                end
                if (last_beat) begin
                    wt_ready <= 1'b0;
                end
            end
        end
    end

    assign busy = (state != IDLE);
    assign done = (state == DONE);

    assign write_addr_0 = waddr;
    assign write_addr_1 = waddr;
    assign write_addr_2 = waddr;
    assign write_addr_3 = waddr;
    assign write_addr_4 = waddr;
    assign write_addr_5 = waddr;
    assign write_addr_6 = waddr;
    assign write_addr_7 = waddr;

    assign write_en_0 = wen[0];
    assign write_en_1 = wen[1];
    assign write_en_2 = wen[2];
    assign write_en_3 = wen[3];
    assign write_en_4 = wen[4];
    assign write_en_5 = wen[5];
    assign write_en_6 = wen[6];
    assign write_en_7 = wen[7];

endmodule

// File: tb/tb_weight_load_ctrl_1x8.sv
// tb/tb_weight_load_ctrl_1x8.sv - self-checking bench for weight_load_ctrl_1x8
module tb_weight_load_ctrl_1x8;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        start;
    logic [9:0]  words_per_bank;
    logic        wt_valid;
    logic [71:0] wt_data;
    logic        wt_ready;
    logic [8:0]  write_addr_0, write_addr_1, write_addr_2, write_addr_3;
    logic [8:0]  write_addr_4, write_addr_5, write_addr_6, write_addr_7;
    logic        write_en_0, write_en_1, write_en_2, write_en_3;
    logic        write_en_4, write_en_5, write_en_6, write_en_7;
    logic [71:0] weight_in;
    logic        busy;
    logic        done;

    weight_load_ctrl_1x8 dut (
        .clk(clk), .rst_n(rst_n), .start(start), .words_per_bank(words_per_bank),
        .wt_valid(wt_valid), .wt_data(wt_data), .wt_ready(wt_ready),
        .write_addr_0(write_addr_0), .write_addr_1(write_addr_1),
        .write_addr_2(write_addr_2), .write_addr_3(write_addr_3),
        .write_addr_4(write_addr_4), .write_addr_5(write_addr_5),
        .write_addr_6(write_addr_6), .write_addr_7(write_addr_7),
        .write_en_0(write_en_0), .write_en_1(write_en_1), .write_en_2(write_en_2),
        .write_en_3(write_en_3), .write_en_4(write_en_4), .write_en_5(write_en_5),
        .write_en_6(write_en_6), .write_en_7(write_en_7),
        .weight_in(weight_in), .busy(busy), .done(done)
    );

    always #5 clk = ~clk;

    typedef struct {
        int wpb;
        int exp_n;
        int mode;
        bit restart;
        int abort_at;
    } vec_t;

    int          n_checks = 0;
    int          n_pass   = 0;
    logic [8:0]  m_addr;
    logic [71:0] m_data;
    vec_t        tbl[7];

    task automatic chk(input string name, input logic [127:0] act, input logic [127:0] exp);
        n_checks++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    endtask

    task automatic check_outputs(input logic [7:0] e_we, input bit e_done, input bit e_busy,
                                 input bit e_ready);
        logic [8:0] addrs [8];
        addrs = '{write_addr_0, write_addr_1, write_addr_2, write_addr_3,
                  write_addr_4, write_addr_5, write_addr_6, write_addr_7};
        chk("write_en", {write_en_7, write_en_6, write_en_5, write_en_4,
                         write_en_3, write_en_2, write_en_1, write_en_0}, e_we);
        chk("done", done, e_done);
        chk("busy", busy, e_busy);
        chk("wt_ready", wt_ready, e_ready);
        chk("weight_in", weight_in, m_data);
        for (int i = 0; i < 8; i++) chk($sformatf("write_addr_%0d", i), addrs[i], m_addr);
    endtask

    // Reference model: beat k of a load goes to bank k/N, address k%N.
    task automatic run_load(input vec_t v);
        int         k      = 0;
        int         writes = 0;
        int         cyc    = 0;
        logic [7:0] e_we   = '0;
        bit         e_done;
        bit         e_load;
        bit         acc;
        @(negedge clk);
        start          = 1'b1;
        words_per_bank = 10'(v.wpb);
        wt_valid       = 1'b0;
        @(negedge clk);
        start  = 1'b0;
        e_done = (v.exp_n == 0);
        e_load = (v.exp_n != 0);
        forever begin
            check_outputs(e_we, e_done, e_load || e_done, e_load);
            writes += $countones({write_en_7, write_en_6, write_en_5, write_en_4,
                                  write_en_3, write_en_2, write_en_1, write_en_0});
            if (e_done) break;
            if (v.abort_at >= 0 && k == v.abort_at) begin
                rst_n    = 1'b0;
                wt_valid = 1'b0;
                #1;
                m_addr = '0;
                m_data = '0;
                check_outputs(8'h00, 1'b0, 1'b0, 1'b0);
                @(negedge clk);
                rst_n = 1'b1;
                return;
            end
            if (cyc > 20000) begin
                chk("load_timeout", 1'b1, 1'b0);
                return;
            end
            if (v.restart) begin
                start          = (cyc == 3);
                words_per_bank = (cyc == 3) ? 10'd2 : 10'(v.wpb);
            end
            case (v.mode)
                0:       wt_valid = 1'b1;
                1:       wt_valid = (cyc % 2 == 0);
                default: wt_valid = ($urandom_range(0, 2) != 0);
            endcase
            wt_data = (v.mode == 2) ? {$urandom, $urandom, 8'($urandom)} : 72'(k);
            acc     = wt_valid && e_load;
            e_we    = '0;
            if (acc) begin
                e_we   = 8'(1 << (k / v.exp_n));
                m_addr = 9'(k % v.exp_n);
                m_data = wt_data;
                k++;
                if (k == 8 * v.exp_n) begin
                    e_done = 1'b1;
                    e_load = 1'b0;
                end
            end
            cyc++;
            @(negedge clk);
            start = 1'b0;
        end
        wt_valid = 1'b1;
        @(negedge clk);
        check_outputs(8'h00, 1'b0, 1'b0, 1'b0);
        wt_valid = 1'b0;
        chk("total_writes", writes, 8 * v.exp_n);
    endtask

    initial begin
        vec_t rv;
        rst_n          = 1'b0;
        start          = 1'b0;
        words_per_bank = '0;
        wt_valid       = 1'b0;
        wt_data        = '0;
        m_addr         = '0;
        m_data         = '0;
        #12;
        check_outputs(8'h00, 1'b0, 1'b0, 1'b0);
        @(negedge clk);
        rst_n = 1'b1;

        tbl[0] = '{4,   4,   0, 1'b0, -1};
        tbl[1] = '{4,   4,   1, 1'b0, -1};
        tbl[2] = '{0,   0,   0, 1'b0, -1};
        tbl[3] = '{4,   4,   0, 1'b1, -1};
        tbl[4] = '{4,   4,   0, 1'b0, 10};
        tbl[5] = '{4,   4,   0, 1'b0, -1};
        tbl[6] = '{517, 512, 0, 1'b0, -1};
        for (int i = 0; i < 7; i++) run_load(tbl[i]);

        for (int i = 0; i < 4; i++) begin
            rv.wpb      = $urandom_range(1, 20);
            rv.exp_n    = (rv.wpb > 512) ? 512 : rv.wpb;
            rv.mode     = 2;
            rv.restart  = 1'b0;
            rv.abort_at = -1;
            run_load(rv);
        end

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule

// File: doc/weight_load_ctrl_1x8.md
WEIGHT_LOAD_CTRL_1X8 -- requirements
Module: weight_load_ctrl_1x8

Interface
REQ-001 SHALL have parameter DEPTH, default 512, words per weight bank.
REQ-002 SHALL have parameter ADDR_BIT, default 9, bank address width.
REQ-003 SHALL have port clk  input  1  single clock; all state updates on rising edge.
REQ-004 SHALL have port rst_n  input  1  reset, asynchronous, active-low.
REQ-005 SHALL have port start  input  1  load request, sampled only in IDLE.
REQ-006 SHALL have port words_per_bank  input  ADDR_BIT+1  words per bank (N), latched on accepted start.
REQ-007 SHALL have port wt_valid  input  1  weight stream beat valid.
REQ-008 SHALL have port wt_data  input  72  weight stream beat (nine 8-bit weights).
REQ-009 SHALL have port wt_ready  output  1  controller accepts beat.
REQ-010 SHALL have ports write_addr_0..write_addr_7  output  ADDR_BIT each  per-bank write address.
REQ-011 SHALL have ports write_en_0..write_en_7  output  1 each  per-bank write enable.
REQ-012 SHALL have port weight_in  output  72  write data shared by all banks.
REQ-013 SHALL have port busy  output  1  high in LOAD and DONE.
REQ-014 SHALL have port done  output  1  one-cycle completion pulse.

Function
REQ-015 SHALL implement FSM states IDLE, LOAD, DONE.
REQ-016 SHALL, in IDLE with start=1, latch N = min(words_per_bank, DEPTH), clear bank and address counters, go to LOAD; N=0 goes to DONE instead.
REQ-017 SHALL ignore start in LOAD and DONE.
REQ-018 SHALL drive wt_ready=1 only in LOAD, as a registered output; beat accepted when wt_valid & wt_ready.
REQ-019 SHALL fill bank-major: beats 0..N-1 to bank 0 addr 0..N-1, beats N..2N-1 to bank 1, ... bank 7; total 8*N beats.
REQ-020 SHALL, one cycle after an accepted beat, register weight_in=wt_data, assert exactly the current bank's write_en_k for one cycle, and drive all write_addr_k = current address.
REQ-021 SHALL hold write_en_0..7 low in every cycle with no write in flight; weight_in and write_addr hold last value.
REQ-022 SHALL, on address = N-1 accept, wrap address to 0 and increment bank; on bank 7 / address N-1 accept, drop wt_ready in the next cycle and enter DONE.
REQ-023 SHALL assert done=1 for exactly the single DONE cycle (coincident with final write_en_7 when N>0), then return to IDLE.
REQ-024 SHALL tolerate wt_valid gaps of any length in LOAD with no write and no counter change.
REQ-025 SHALL not accept any beat beyond 8*N.

Reset
REQ-026 SHALL, on rst_n=0, asynchronously force IDLE, wt_ready=0, all write_en_k=0, all write_addr_k=0, weight_in=0, busy=0, done=0, counters and latched N to 0.
REQ-027 SHALL abandon a load in progress on reset; partially written banks are not restored; next start begins from bank 0 addr 0.

Verification
REQ-028 N=4, start, 32 back-to-back beats data=beat index -> bank0 addr0..3 data 0..3, ..., bank7 addr0..3 data 28..31; done high with bank7 addr3 write; busy low next cycle.
REQ-029 N=4, wt_valid toggled 1-0-1-0 -> identical write sequence, one write per accepted beat, no writes in gap cycles.
REQ-030 words_per_bank=0, start -> no write_en ever, wt_ready stays 0, done pulses 1 cycle after start edge.
REQ-031 words_per_bank=DEPTH+5 -> N clamped to DEPTH; bank0 addr wraps DEPTH-1 -> 0 into bank1; 8*DEPTH beats total.
REQ-032 start reasserted during LOAD with words_per_bank=2 (original N=4) -> ignored; load completes with N=4.
REQ-033 rst_n low after 10 beats of N=4 -> all outputs 0 immediately; new start writes bank0 addr0 first.
